// File: rtl/alu_4bit_arbiter.sv
// Two-requester round-robin arbiter in front of a 4-bit ALU. The result is registered one cycle after accept.
// A single response slot is held until rsp_ready. Both requester readies stay low while the slot is occupied.
module alu_4bit_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic [1:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic [1:0]       req1_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic             rsp_zero,
  output logic             rsp_id,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ptr;
  logic [3:0]       r_res;
  logic             r_zero;
  logic             r_id;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_gnt_vld;
  logic             w_gnt_id;
  logic             w_acc;
  logic             w_rsp_hs;
  logic [3:0]       w_a;
  logic [3:0]       w_b;
  logic [1:0]       w_sel;
  logic [3:0]       w_res;

  // r_ptr holds the last served index; on a tie the other requester wins.
  assign w_gnt_vld = req0_valid | req1_valid;
  assign w_gnt_id  = req1_valid & (~req0_valid | ~r_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_acc)     w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    w_acc      = 1'b0;
    w_rsp_hs   = 1'b0;
    if (r_state == S_IDLE) begin
      req0_ready = w_gnt_vld & ~w_gnt_id;
      req1_ready = w_gnt_vld &  w_gnt_id;
      w_acc      = w_gnt_vld;
    end else begin
      w_rsp_hs   = rsp_ready;
    end
  end

  assign w_a   = w_gnt_id ? req1_a   : req0_a;
  assign w_b   = w_gnt_id ? req1_b   : req0_b;
  assign w_sel = w_gnt_id ? req1_sel : req0_sel;

  always_comb begin
    w_res = 4'd0;
    case (w_sel)
      2'b00: w_res = w_a + w_b;
      2'b01: w_res = w_a + ~w_b + 4'd1;
      2'b10: w_res = w_a & w_b;
      2'b11: w_res = w_a | w_b;
      default: w_res = 4'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res  <= 4'd0;
      r_zero <= 1'b0;
      r_id   <= 1'b0;
      r_ptr  <= 1'b1;
    end else if (w_acc) begin
      r_res  <= w_res;
      r_zero <= (w_res == 4'd0);
      r_id   <= w_gnt_id;
      r_ptr  <= w_gnt_id;
    end
  end

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_rsp_hs) begin
      if (!r_id && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + 1'b1;
      if ( r_id && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_result = r_res;
  assign rsp_zero   = r_zero;
  assign rsp_id     = r_id;
  assign done_cnt0  = r_cnt0;
  assign done_cnt1  = r_cnt1;

endmodule

// File: tb/tb_alu_4bit_arbiter.sv
// Directed bench for alu_4bit_arbiter, built with CNT_W=2 so counter saturation is reachable.
module tb_alu_4bit_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a = 4'd0, req0_b = 4'd0, req1_a = 4'd0, req1_b = 4'd0;
  logic [1:0] req0_sel = 2'd0, req1_sel = 2'd0;
  logic       rsp_valid, rsp_ready = 1'b1;
  logic [3:0] rsp_result;
  logic       rsp_zero, rsp_id;
  logic [1:0] done_cnt0, done_cnt1;

  int errors = 0;
  int checks = 0;

  alu_4bit_arbiter #(.CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_id(rsp_id), .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    rst_n      = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  // Present one operation on a requester for a single accept edge, then withdraw it.
  task automatic drive_op(input bit id, input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
    if (!id) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel; end
    else     begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel; end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rsp_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_result !== 4'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", rsp_result); end
    checks++; if ({rsp_zero, rsp_id} !== 2'b00) begin errors++; $display("FAIL reset_zero_id got=%b exp=00", {rsp_zero, rsp_id}); end
    checks++; if ({done_cnt0, done_cnt1} !== 4'd0) begin errors++; $display("FAIL reset_cnts got=%h exp=0", {done_cnt0, done_cnt1}); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_readies got=%b exp=00", {req0_ready, req1_ready}); end
  endtask

  task automatic test_add_req0();
    do_reset();
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd4; req0_sel = 2'b00;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL add_readies got=%b exp=10", {req0_ready, req1_ready}); end
    step();
    req0_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", rsp_valid); end
    checks++; if ({rsp_result, rsp_zero, rsp_id} !== {4'd7, 1'b0, 1'b0}) begin errors++; $display("FAIL add_rsp got=%h/%b/%b exp=7/0/0", rsp_result, rsp_zero, rsp_id); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_release got=%b exp=0", rsp_valid); end
    checks++; if (done_cnt0 !== 2'd1) begin errors++; $display("FAIL add_cnt0 got=%0d exp=1", done_cnt0); end
  endtask

  task automatic test_sub_req1();
    do_reset();
    drive_op(1'b1, 4'd5, 4'd5, 2'b01);
    checks++; if ({rsp_result, rsp_zero, rsp_id} !== {4'd0, 1'b1, 1'b1}) begin errors++; $display("FAIL sub_eq got=%h/%b/%b exp=0/1/1", rsp_result, rsp_zero, rsp_id); end
    step();
    drive_op(1'b1, 4'd2, 4'd5, 2'b01);
    checks++; if ({rsp_result, rsp_zero, rsp_id} !== {4'hD, 1'b0, 1'b1}) begin errors++; $display("FAIL sub_neg got=%h/%b/%b exp=d/0/1", rsp_result, rsp_zero, rsp_id); end
    step();
    checks++; if ({done_cnt0, done_cnt1} !== {2'd0, 2'd2}) begin errors++; $display("FAIL sub_cnts got=%0d/%0d exp=0/2", done_cnt0, done_cnt1); end
  endtask

  task automatic test_logic_ops();
    do_reset();
    drive_op(1'b0, 4'hF, 4'h1, 2'b00);
    checks++; if ({rsp_result, rsp_zero} !== {4'h0, 1'b1}) begin errors++; $display("FAIL add_wrap got=%h/%b exp=0/1", rsp_result, rsp_zero); end
    step();
    drive_op(1'b0, 4'hC, 4'hA, 2'b10);
    checks++; if ({rsp_result, rsp_zero} !== {4'h8, 1'b0}) begin errors++; $display("FAIL and_op got=%h/%b exp=8/0", rsp_result, rsp_zero); end
    step();
    drive_op(1'b0, 4'hC, 4'hA, 2'b11);
    checks++; if ({rsp_result, rsp_zero} !== {4'hE, 1'b0}) begin errors++; $display("FAIL or_op got=%h/%b exp=e/0", rsp_result, rsp_zero); end
    step();
  endtask

  task automatic test_back_to_back();
    logic exp_id;
    do_reset();
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_sel = 2'b00;
    req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd2; req1_sel = 2'b01;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_id = k[0];
      checks++; if ({req0_ready, req1_ready} !== {~exp_id, exp_id}) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", k, {req0_ready, req1_ready}, {~exp_id, exp_id}); end
      step();
      checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, exp_id, (exp_id ? 4'd5 : 4'd2)}) begin errors++; $display("FAIL rr_rsp%0d got=%b/%b/%h", k, rsp_valid, rsp_id, rsp_result); end
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL rr_busy%0d got=%b exp=00", k, {req0_ready, req1_ready}); end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if ({done_cnt0, done_cnt1} !== {2'd2, 2'd2}) begin errors++; $display("FAIL rr_cnts got=%0d/%0d exp=2/2", done_cnt0, done_cnt1); end
  endtask

  task automatic test_stall();
    do_reset();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd3; req0_sel = 2'b00;
    req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1; req1_sel = 2'b10;
    step();
    for (int k = 0; k < 5; k++) begin
      req0_a = 4'(k); req0_sel = 2'b11;
      #1;
      checks++; if ({rsp_valid, rsp_result, rsp_zero, rsp_id} !== {1'b1, 4'hC, 1'b0, 1'b0}) begin errors++; $display("FAIL stall_hold%0d got=%b/%h/%b/%b exp=1/c/0/0", k, rsp_valid, rsp_result, rsp_zero, rsp_id); end
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL stall_ready%0d got=%b exp=00", k, {req0_ready, req1_ready}); end
      step();
    end
    rsp_ready = 1'b1;
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_release got=%b exp=0", rsp_valid); end
    checks++; if ({done_cnt0, done_cnt1} !== {2'd1, 2'd0}) begin errors++; $display("FAIL stall_cnts got=%0d/%0d exp=1/0", done_cnt0, done_cnt1); end
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL stall_next_grant got=%b exp=01", {req0_ready, req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_drop_valid();
    do_reset();
    req1_valid = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL drop_solo got=%b exp=01", {req0_ready, req1_ready}); end
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL drop_ptr got=%b exp=01", {req0_ready, req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_saturate_and_reset();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive_op(1'b0, 4'd1, 4'd2, 2'b00);
      step();
      if (k == 2) begin
        checks++; if (done_cnt0 !== 2'd3) begin errors++; $display("FAIL sat_reach got=%0d exp=3", done_cnt0); end
      end
    end
    checks++; if (done_cnt0 !== 2'd3) begin errors++; $display("FAIL sat_hold got=%0d exp=3", done_cnt0); end
    rsp_ready = 1'b0;
    drive_op(1'b1, 4'd6, 4'd1, 2'b11);
    checks++; if ({rsp_valid, rsp_result} !== {1'b1, 4'd7}) begin errors++; $display("FAIL rst_pre got=%b/%h exp=1/7", rsp_valid, rsp_result); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({rsp_valid, rsp_result, rsp_id} !== {1'b0, 4'd0, 1'b0}) begin errors++; $display("FAIL rst_async got=%b/%h/%b exp=0/0/0", rsp_valid, rsp_result, rsp_id); end
    checks++; if ({done_cnt0, done_cnt1} !== 4'd0) begin errors++; $display("FAIL rst_cnts got=%0d/%0d exp=0/0", done_cnt0, done_cnt1); end
    rsp_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    checks++; if ({rsp_valid, done_cnt1} !== {1'b0, 2'd0}) begin errors++; $display("FAIL rst_after got=%b/%0d exp=0/0", rsp_valid, done_cnt1); end
  endtask

  initial begin
    test_reset();
    test_add_req0();
    test_sub_req1();
    test_logic_ops();
    test_back_to_back();
    test_stall();
    test_drop_valid();
    test_saturate_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_4bit_arbiter.md
ALU_4BIT_ARBITER -- requirements
Module: alu_4bit_arbiter

Interface
REQ-001 Parameter CNT_W, default 8: width of each per-requester completed-operation counter.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  arbiter accepts requester 0 operation this cycle.
REQ-006 req0_a, req0_b  input  4 each  requester 0 operands.
REQ-007 req0_sel  input  2  requester 0 op-code: 00 add, 01 sub, 10 AND, 11 OR.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_sel  same as REQ-004..REQ-007, for requester 1.
REQ-009 rsp_valid  output  1  registered result available.
REQ-010 rsp_ready  input  1  consumer takes result this cycle.
REQ-011 rsp_result  output  4  operation result.
REQ-012 rsp_zero  output  1  1 when rsp_result == 0.
REQ-013 rsp_id  output  1  requester index that issued the operation.
REQ-014 done_cnt0, done_cnt1  output  CNT_W each  completed-response counts per requester.

Function
REQ-015 Two states, IDLE and RESP; exactly one operation outstanding at most.
REQ-016 IDLE: reqN_ready = 1 only for the granted requester; both readies 0 in RESP.
REQ-017 Grant in IDLE: single valid requester is granted; both valid -> grant the requester not served last (round-robin pointer).
REQ-018 Round-robin pointer updates only on an accepted operation (valid & ready), to the accepted index.
REQ-019 Readies are combinational from state, pointer and valids; they never depend on rsp_ready.
REQ-020 Accept (valid & ready in IDLE) -> next edge: capture result, zero flag and id; rsp_valid = 1; state RESP; latency 1 cycle.
REQ-021 Arithmetic, all modulo 16: add = A+B; sub = A+~B+1 (= A-B); AND = A&B; OR = A|B; carry/borrow discarded.
REQ-022 rsp_zero = (result == 0), computed from the captured result; for sub, A == B gives rsp_zero = 1.
REQ-023 RESP: rsp_result, rsp_zero, rsp_id held stable while rsp_valid & !rsp_ready.
REQ-024 RESP with rsp_ready = 1 -> next edge: rsp_valid = 0, state IDLE, done_cnt[rsp_id] increments.
REQ-025 No accept occurs in the same cycle as the response handshake; minimum issue interval is 2 cycles per operation.
REQ-026 Requester operands/op-code only sampled on the accept edge; changes while not ready are ignored.
REQ-027 done_cnt saturates at 2^CNT_W-1; no wrap.
REQ-028 A requester dropping valid before being accepted loses its turn without a pointer update.

Reset
REQ-029 rst_n low asynchronously forces: state IDLE, rsp_valid 0, rsp_result 0, rsp_zero 0, rsp_id 0, done_cnt0/1 0, pointer = 1 (requester 0 wins first tie).
REQ-030 Reset asserted in RESP discards the pending result; no counter increments.
REQ-031 Outputs and readies are valid starting the first edge after rst_n deasserts.

Verification
REQ-032 req0 only, a=3 b=4 sel=00, rsp_ready=1 -> rsp_valid next cycle, result 7, zero 0, id 0; done_cnt0 = 1.
REQ-033 req1 a=5 b=5 sel=01 -> result 0, zero 1, id 1; a=2 b=5 sel=01 -> result 13 (0xD), zero 0.
REQ-034 Both valid continuously after reset, rsp_ready=1 -> ids alternate 0,1,0,1; accept every 2nd cycle.
REQ-035 rsp_ready held 0 for 5 cycles -> rsp_* stable, both readies 0, no second accept; then rsp_ready=1 -> release, return IDLE.
REQ-036 a=0xF b=0x1 sel=00 -> result 0, zero 1; sel=10 a=0xC b=0xA -> 8; sel=11 -> 0xE.
REQ-037 CNT_W=2, 5 req0 ops -> done_cnt0 saturates at 3; rst_n pulse in RESP -> rsp_valid 0 immediately, counters 0.
